fir_channel_scheduler: RTL and testbench

//  Time-shares one single-channel FIR MAC engine (block-RAM FIR) between CH input channels.

---
 rtl/fir_channel_scheduler.sv | 170 +++++++++++++++++
 tb/tb_fir_channel_scheduler.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_channel_scheduler.sv
// Round-robin scheduler that time-shares one FIR MAC engine between CH sample channels.
// It holds one pending sample per channel and routes each engine result back to its channel.
`timescale 1ns/1ps

module fir_channel_scheduler #(
    parameter int DW      = 16,
    parameter int CH      = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                                clk_i,
    input  logic                                srst_i,
    input  logic [CH-1:0]                       sample_valid_i,
    input  logic [CH*DW-1:0]                    data_i,
    output logic                                eng_start_o,
    output logic [DW-1:0]                       eng_data_o,
    output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] eng_ch_o,
    input  logic                                eng_done_i,
    input  logic [DW-1:0]                       eng_data_i,
    output logic [CH*DW-1:0]                    data_o,
    output logic [CH-1:0]                       data_valid_o,
    output logic [CH-1:0]                       overrun_o,
    output logic                                timeout_o
);

    localparam int CHW  = (CH > 1) ? $clog2(CH) : 1;
    localparam int CNTW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [CH-1:0]           pend_q, pend_d;
    logic [CH-1:0][DW-1:0]   pend_data_q, pend_data_d;
    logic [CHW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [CHW-1:0]          eng_ch_q, eng_ch_d;
    logic [DW-1:0]           eng_data_q, eng_data_d;
    logic                    eng_start_q, eng_start_d;
    logic [CNTW-1:0]         cnt_q, cnt_d;
    logic [CH-1:0][DW-1:0]   data_q, data_d;
    logic [CH-1:0]           data_valid_q, data_valid_d;
    logic [CH-1:0]           overrun_q, overrun_d;
    logic                    timeout_q, timeout_d;

    logic [CH-1:0][DW-1:0]   data_in;
    logic                    grant_found;
    logic [CHW-1:0]          grant_idx;
    logic                    grant_now;
    int                      scan_idx;
    logic [CHW-1:0]          scan_sel;

    assign data_in = data_i;

    // Scan rr_ptr+1, rr_ptr+2, ... (mod CH) and take the first pending channel.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        scan_sel    = '0;
        for (int i = 1; i <= CH; i++) begin
            scan_idx = int'(rr_ptr_q) + i;
            if (scan_idx >= CH) scan_idx = scan_idx - CH;
            scan_sel = CHW'(scan_idx);
            if (!grant_found && pend_q[scan_sel]) begin
                grant_found = 1'b1;
                grant_idx   = scan_sel;
            end
        end
    end

    assign grant_now = (state_q == ST_IDLE) && grant_found;

    // NOTE: every *_d gets a default first so the combinational block cannot infer a latch.
    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        pend_data_d  = pend_data_q;
        rr_ptr_d     = rr_ptr_q;
        eng_ch_d     = eng_ch_q;
        eng_data_d   = eng_data_q;
        eng_start_d  = 1'b0;
        cnt_d        = cnt_q;
        data_d       = data_q;
        data_valid_d = '0;
        overrun_d    = '0;
        timeout_d    = 1'b0;

        // Clear before set so a strobe on the channel being granted keeps it pending.
        for (int k = 0; k < CH; k++) begin
            if (grant_now && (grant_idx == CHW'(k))) pend_d[k] = 1'b0;
            if (sample_valid_i[k]) begin
                pend_d[k]      = 1'b1;
                pend_data_d[k] = data_in[k];
                if (pend_q[k] && !(grant_now && (grant_idx == CHW'(k))))
                    overrun_d[k] = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    eng_ch_d    = grant_idx;
                    eng_data_d  = pend_data_q[grant_idx];
                    rr_ptr_d    = grant_idx;
                    eng_start_d = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (eng_done_i) begin
                    data_d[eng_ch_q]       = eng_data_i;
                    data_valid_d[eng_ch_q] = 1'b1;
                    state_d                = ST_IDLE;
                end else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q      <= ST_IDLE;
            pend_q       <= '0;
            rr_ptr_q     <= CHW'(CH - 1);
            eng_ch_q     <= '0;
            eng_data_q   <= '0;
            eng_start_q  <= 1'b0;
            cnt_q        <= '0;
            data_q       <= '0;
            data_valid_q <= '0;
            overrun_q    <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            rr_ptr_q     <= rr_ptr_d;
            eng_ch_q     <= eng_ch_d;
            eng_data_q   <= eng_data_d;
            eng_start_q  <= eng_start_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
        end
    end

    // NOTE: sample storage is left unreset; it is only ever read while its pend bit is set.
    always_ff @(posedge clk_i) begin
        pend_data_q <= pend_data_d;
    end

    assign eng_start_o  = eng_start_q;
    assign eng_data_o   = eng_data_q;
    assign eng_ch_o     = eng_ch_q;
    assign data_o       = data_q;
    assign data_valid_o = data_valid_q;
    assign overrun_o    = overrun_q;
    assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Self-checking bench for fir_channel_scheduler: a fixed-latency engine model plus
// scoreboard queues of expected engine jobs and expected per-channel results.
`timescale 1ns/1ps

module tb_fir_channel_scheduler;

    localparam int DW      = 16;
    localparam int CH      = 2;
    localparam int CHW     = 1;
    localparam int TIMEOUT = 16;
    localparam int LAT     = 10;
    localparam logic [DW-1:0] KEY = 16'h1888;   // engine model: result = sample ^ KEY

    typedef struct {
        int            ch;
        logic [DW-1:0] data;
    } job_t;

    logic              clk = 1'b0;
    logic              srst_i = 1'b1;
    logic [CH-1:0]     sample_valid_i = '0;
    logic [CH*DW-1:0]  data_i = '0;
    logic              eng_start_o;
    logic [DW-1:0]     eng_data_o;
    logic [CHW-1:0]    eng_ch_o;
    logic              eng_done_i;
    logic [DW-1:0]     eng_data_i;
    logic [CH*DW-1:0]  data_o;
    logic [CH-1:0]     data_valid_o;
    logic [CH-1:0]     overrun_o;
    logic              timeout_o;

    logic              model_done = 1'b0;
    logic [DW-1:0]     model_data = '0;
    logic              inj_done = 1'b0;
    logic [DW-1:0]     inj_data = '0;
    logic              eng_enable = 1'b1;

    assign eng_done_i = model_done | inj_done;
    assign eng_data_i = inj_done ? inj_data : model_data;

    job_t issue_q[$];
    job_t out_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int start_cyc = 0;
    int valid_cyc = 0;
    int done_cyc = 0;
    int starts_seen = 0;
    int ovr0 = 0;
    int ovr1 = 0;
    int timeouts = 0;

    fir_channel_scheduler #(.DW(DW), .CH(CH), .TIMEOUT(TIMEOUT)) dut (
        .clk_i          (clk),
        .srst_i         (srst_i),
        .sample_valid_i (sample_valid_i),
        .data_i         (data_i),
        .eng_start_o    (eng_start_o),
        .eng_data_o     (eng_data_o),
        .eng_ch_o       (eng_ch_o),
        .eng_done_i     (eng_done_i),
        .eng_data_i     (eng_data_i),
        .data_o         (data_o),
        .data_valid_o   (data_valid_o),
        .overrun_o      (overrun_o),
        .timeout_o      (timeout_o)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Engine model: result LAT cycles after the start strobe is seen.
    initial begin
        logic [DW-1:0] captured;
        forever begin
            @(negedge clk);
            if (eng_start_o === 1'b1 && eng_enable) begin
                captured = eng_data_o;
                repeat (LAT) @(negedge clk);
                model_done = 1'b1;
                model_data = captured ^ KEY;
                done_cyc   = cyc;
                @(negedge clk);
                model_done = 1'b0;
            end
        end
    end

    // Scoreboard monitor: pops expected jobs/results as the DUT produces them.
    initial begin
        job_t          e;
        logic [CH-1:0] exp_mask;
        forever begin
            @(negedge clk);
            if (eng_start_o === 1'b1) begin
                starts_seen++;
                start_cyc = cyc;
                n_cmp++;
                if (issue_q.size() == 0) begin
                    n_err++;
                    $display("FAIL issue_unexpected: got start ch=%0d data=%h, required no start",
                             eng_ch_o, eng_data_o);
                end else begin
                    e = issue_q.pop_front();
                    if (eng_ch_o !== CHW'(e.ch) || eng_data_o !== e.data) begin
                        n_err++;
                        $display("FAIL issue_job: got ch=%0d data=%h, required ch=%0d data=%h",
                                 eng_ch_o, eng_data_o, e.ch, e.data);
                    end
                end
            end
            if (data_valid_o !== '0) begin
                valid_cyc = cyc;
                n_cmp++;
                if (out_q.size() == 0) begin
                    n_err++;
                    $display("FAIL result_unexpected: got data_valid_o=%b, required 00", data_valid_o);
                end else begin
                    e = out_q.pop_front();
                    exp_mask = '0;
                    exp_mask[e.ch] = 1'b1;
                    if (data_valid_o !== exp_mask || data_o[e.ch*DW +: DW] !== e.data) begin
                        n_err++;
                        $display("FAIL result_route: got valid=%b data=%h, required valid=%b data=%h",
                                 data_valid_o, data_o[e.ch*DW +: DW], exp_mask, e.data);
                    end
                end
            end
            if (overrun_o[0] === 1'b1) ovr0++;
            if (overrun_o[1] === 1'b1) ovr1++;
            if (timeout_o === 1'b1) timeouts++;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_watchdog: simulation still running, required to finish");
        $fatal(1, "bench watchdog expired");
    end

    task automatic apply_reset();
        srst_i = 1'b1;
        repeat (3) @(negedge clk);
        srst_i = 1'b0;
    endtask

    // Called at a negedge; holds the strobe for one cycle and returns at the next negedge.
    task automatic strobe(input logic [CH-1:0] mask, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        sample_valid_i = mask;
        data_i         = {d1, d0};
        @(negedge clk);
        sample_valid_i = '0;
    endtask

    task automatic push_job(input int ch, input logic [DW-1:0] d, input bit expect_result);
        job_t j;
        j.ch   = ch;
        j.data = d;
        issue_q.push_back(j);
        if (expect_result) begin
            j.data = d ^ KEY;
            out_q.push_back(j);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((issue_q.size() != 0 || out_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n >= 200) begin
            n_err++;
            $display("FAIL %s_drain: %0d jobs / %0d results outstanding, required 0 / 0",
                     name, issue_q.size(), out_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if ({eng_start_o, eng_ch_o, eng_data_o} !== '0) begin
            n_err++;
            $display("FAIL reset_engine: got start=%b ch=%0d data=%h, required 0/0/0000",
                     eng_start_o, eng_ch_o, eng_data_o);
        end
        n_cmp++;
        if (data_o !== '0 || data_valid_o !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got data_o=%h valid=%b, required 0", data_o, data_valid_o);
        end
        n_cmp++;
        if (overrun_o !== '0 || timeout_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: got overrun=%b timeout=%b, required 00/0", overrun_o, timeout_o);
        end
    endtask

    task automatic test_single();
        int s;
        s = cyc;
        push_job(0, 16'h1234, 1'b1);
        strobe(2'b01, 16'h1234, 16'h0000);
        wait_drain("single");
        n_cmp++;
        if (start_cyc - s !== 2) begin
            n_err++;
            $display("FAIL single_start_latency: got %0d cycles, required 2", start_cyc - s);
        end
        n_cmp++;
        if (valid_cyc - done_cyc !== 1) begin
            n_err++;
            $display("FAIL single_result_latency: got %0d cycles, required 1", valid_cyc - done_cyc);
        end
        n_cmp++;
        if (data_o[15:0] !== 16'h0ABC) begin
            n_err++;
            $display("FAIL single_data_held: got %h, required 0abc", data_o[15:0]);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        push_job(0, 16'h1111, 1'b1);
        push_job(1, 16'h2222, 1'b1);
        strobe(2'b11, 16'h1111, 16'h2222);
        wait_drain("rr_first");
        push_job(0, 16'h3333, 1'b1);
        push_job(1, 16'h4444, 1'b1);
        strobe(2'b11, 16'h3333, 16'h4444);
        wait_drain("rr_second");
        n_cmp++;
        if (data_o !== {16'h4444 ^ KEY, 16'h3333 ^ KEY}) begin
            n_err++;
            $display("FAIL rr_outputs: got %h, required %h", data_o, {16'h4444 ^ KEY, 16'h3333 ^ KEY});
        end
    endtask

    task automatic test_overrun();
        ovr0 = 0;
        ovr1 = 0;
        push_job(0, 16'h0100, 1'b1);
        strobe(2'b01, 16'h0100, 16'h0000);
        repeat (4) @(negedge clk);
        push_job(1, 16'h0002, 1'b1);
        strobe(2'b10, 16'h0000, 16'h0001);
        strobe(2'b10, 16'h0000, 16'h0002);
        wait_drain("overrun");
        n_cmp++;
        if (ovr1 !== 1 || ovr0 !== 0) begin
            n_err++;
            $display("FAIL overrun_count: got ch0=%0d ch1=%0d pulses, required 0 / 1", ovr0, ovr1);
        end
    endtask

    task automatic test_timeout();
        logic [CH*DW-1:0] snap;
        int               t0;
        int               n;
        snap       = data_o;
        timeouts   = 0;
        eng_enable = 1'b0;
        push_job(0, 16'h7777, 1'b0);
        strobe(2'b01, 16'h7777, 16'h0000);
        repeat (3) @(negedge clk);
        t0 = start_cyc;
        push_job(1, 16'h5555, 1'b1);
        strobe(2'b10, 16'h0000, 16'h5555);
        n = 0;
        while (timeout_o !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n >= 100) begin
            n_err++;
            $display("FAIL timeout_seen: got no timeout_o pulse, required one");
        end
        n_cmp++;
        if (cyc - t0 !== TIMEOUT + 1) begin
            n_err++;
            $display("FAIL timeout_latency: got %0d cycles after start, required %0d", cyc - t0, TIMEOUT + 1);
        end
        n_cmp++;
        if (data_o !== snap || data_valid_o !== '0) begin
            n_err++;
            $display("FAIL timeout_no_update: got data_o=%h valid=%b, required %h / 00",
                     data_o, data_valid_o, snap);
        end
        eng_enable = 1'b1;
        wait_drain("timeout_next");
        n_cmp++;
        if (timeouts !== 1) begin
            n_err++;
            $display("FAIL timeout_count: got %0d pulses, required 1", timeouts);
        end
    endtask

    task automatic test_reset_mid_job();
        int s0;
        eng_enable = 1'b0;
        push_job(0, 16'h0AAA, 1'b0);
        strobe(2'b01, 16'h0AAA, 16'h0000);
        repeat (4) @(negedge clk);
        strobe(2'b01, 16'h0BBB, 16'h0000);
        srst_i = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({eng_start_o, eng_ch_o, eng_data_o, data_o, data_valid_o, overrun_o, timeout_o} !== '0) begin
            n_err++;
            $display("FAIL midreset_outputs: got start=%b ch=%0d eng=%h data_o=%h valid=%b ovr=%b to=%b, required all 0",
                     eng_start_o, eng_ch_o, eng_data_o, data_o, data_valid_o, overrun_o, timeout_o);
        end
        srst_i = 1'b0;
        s0 = starts_seen;
        @(negedge clk);
        inj_done = 1'b1;
        inj_data = 16'hDEAD;
        @(negedge clk);
        inj_done = 1'b0;
        repeat (12) @(negedge clk);
        n_cmp++;
        if (starts_seen - s0 !== 0 || data_o !== '0) begin
            n_err++;
            $display("FAIL midreset_idle: got %0d starts data_o=%h, required 0 starts data_o=0",
                     starts_seen - s0, data_o);
        end
        eng_enable = 1'b1;
        push_job(1, 16'h0CCC, 1'b1);
        strobe(2'b10, 16'h0000, 16'h0CCC);
        wait_drain("midreset_new");
    endtask

    task automatic test_back_to_back_same_channel();
        int s;
        ovr0 = 0;
        s = cyc;
        push_job(0, 16'h0101, 1'b1);
        push_job(0, 16'h0202, 1'b1);
        strobe(2'b01, 16'h0101, 16'h0000);
        strobe(2'b01, 16'h0202, 16'h0000);
        @(negedge clk);
        n_cmp++;
        if (start_cyc - s !== 2) begin
            n_err++;
            $display("FAIL samecycle_first_start: got %0d cycles, required 2", start_cyc - s);
        end
        wait_drain("samecycle");
        n_cmp++;
        if (ovr0 !== 0) begin
            n_err++;
            $display("FAIL samecycle_overrun: got %0d pulses, required 0", ovr0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_overrun();
        test_timeout();
        test_reset_mid_job();
        test_back_to_back_same_channel();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
